// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block and the display multiplexer.
package operand_entry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER_A,
        ST_ENTER_B,
        ST_WAIT_ALU,
        ST_SHOW_RES
    } state_t;

    // Command codes carried on key_num when key_tipo=1
    localparam logic [3:0] KEY_EQ_CODE  = 4'hE;
    localparam logic [3:0] KEY_CLR_CODE = 4'hF;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_D = 2'd3;

    // Display source select codes
    localparam logic [2:0] OE_BLANK = 3'd0;
    localparam logic [2:0] OE_REG1  = 3'd1;
    localparam logic [2:0] OE_REG2  = 3'd2;
    localparam logic [2:0] OE_RES   = 3'd3;

    // Command codes 0..3 select an ALU operator
    function automatic logic is_operator_code(input logic [3:0] code);
        return code <= {2'b00, OP_D};
    endfunction

endpackage

// File: rtl/operand_entry_key_strobe.sv
// Turns the level-type key_valid into a single-cycle key event and
// captures the key value that came with it.
module key_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_num,
    input  logic       key_tipo,
    output logic       evt,
    output logic [3:0] evt_num,
    output logic       evt_tipo
);

    logic valid_q;

    // Rising-edge detect on key_valid; key fields latched only on the edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            evt      <= 1'b0;
            evt_num  <= '0;
            evt_tipo <= 1'b0;
        end else begin
            valid_q <= key_valid;
            evt     <= key_valid & ~valid_q;
            if (key_valid && !valid_q) begin
                evt_num  <= key_num;
                evt_tipo <= key_tipo;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Builds two BCD operands from keypad events, latches the operator,
// starts the ALU and selects the display source for each phase.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter logic [3:0]  KEY_EQ  = KEY_EQ_CODE,
    parameter logic [3:0]  KEY_CLR = KEY_CLR_CODE,
    localparam int unsigned W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_num,
    input  logic         key_tipo,
    input  logic         alu_done,
    input  logic [W-1:0] res,
    output logic [W-1:0] reg1,
    output logic [W-1:0] reg2,
    output logic [1:0]   op,
    output logic [2:0]   OE,
    output logic         alu_start,
    output logic         entry_full
);

    localparam int unsigned    CW   = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam logic [CW-1:0]  FULL = CW'(DIGITS);

    logic          evt;
    logic [3:0]    evt_num;
    logic          evt_tipo;
    logic          is_digit, is_oper, is_eq, is_clr;
    logic [CW-1:0] count;
    logic [W-1:0]  digit_only;
    state_t        state;

    key_strobe u_strobe (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_num  (key_num),
        .key_tipo (key_tipo),
        .evt      (evt),
        .evt_num  (evt_num),
        .evt_tipo (evt_tipo)
    );

    assign is_digit   = evt && !evt_tipo && (evt_num <= 4'd9);
    assign is_oper    = evt && evt_tipo && is_operator_code(evt_num);
    assign is_eq      = evt && evt_tipo && (evt_num == KEY_EQ);
    assign is_clr     = evt && evt_tipo && (evt_num == KEY_CLR);
    assign digit_only = {{(W-4){1'b0}}, evt_num};

    // Entry FSM with operand shift registers; every output is registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            reg1       <= '0;
            reg2       <= '0;
            op         <= '0;
            OE         <= OE_BLANK;
            alu_start  <= 1'b0;
            entry_full <= 1'b0;
            count      <= '0;
        end else begin
            alu_start <= 1'b0;
            // Clear overrides everything, including a simultaneous alu_done
            if (is_clr) begin
                state      <= ST_IDLE;
                reg1       <= '0;
                reg2       <= '0;
                op         <= '0;
                OE         <= OE_BLANK;
                entry_full <= 1'b0;
                count      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (is_digit) begin
                            reg1       <= digit_only;
                            count      <= ONE;
                            entry_full <= (ONE == FULL);
                            OE         <= OE_REG1;
                            state      <= ST_ENTER_A;
                        end
                    end
                    ST_ENTER_A: begin
                        if (is_digit) begin
                            if (count != FULL) begin
                                reg1       <= {reg1[W-5:0], evt_num};
                                count      <= count + ONE;
                                entry_full <= ((count + ONE) == FULL);
                            end
                        end else if (is_oper) begin
                            op         <= evt_num[1:0];
                            reg2       <= '0;
                            count      <= '0;
                            entry_full <= 1'b0;
                            OE         <= OE_REG2;
                            state      <= ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (is_digit) begin
                            if (count != FULL) begin
                                reg2       <= {reg2[W-5:0], evt_num};
                                count      <= count + ONE;
                                entry_full <= ((count + ONE) == FULL);
                            end
                        end else if (is_oper) begin
                            if (count == '0) begin
                                op <= evt_num[1:0];
                            end
                        end else if (is_eq) begin
                            if (count != '0) begin
                                alu_start  <= 1'b1;
                                entry_full <= 1'b0;
                                state      <= ST_WAIT_ALU;
                            end
                        end
                    end
                    ST_WAIT_ALU: begin
                        if (alu_done) begin
                            OE    <= OE_RES;
                            state <= ST_SHOW_RES;
                        end
                    end
                    ST_SHOW_RES: begin
                        if (is_digit) begin
                            reg1       <= digit_only;
                            reg2       <= '0;
                            count      <= ONE;
                            entry_full <= (ONE == FULL);
                            OE         <= OE_REG1;
                            state      <= ST_ENTER_A;
                        end else if (is_oper) begin
                            reg1       <= res;
                            reg2       <= '0;
                            op         <= evt_num[1:0];
                            count      <= '0;
                            entry_full <= 1'b0;
                            OE         <= OE_REG2;
                            state      <= ST_ENTER_B;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed and randomized checks of operand_entry against a decimal-valued
// reference model of the calculator entry sequence.
module tb_operand_entry;
    import operand_entry_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_num = '0;
    logic        key_tipo = 1'b0;
    logic        alu_done = 1'b0;
    logic [15:0] res = '0;
    logic [15:0] reg1, reg2;
    logic [1:0]  op;
    logic [2:0]  OE;
    logic        alu_start, entry_full;

    int passed = 0;
    int total  = 0;
    int starts = 0;

    // Reference model: operands kept as decimal numbers, phases as plain ints
    // (0 idle, 1 first operand, 2 second operand, 3 waiting, 4 result shown)
    int m_ph = 0, m_a = 0, m_b = 0, m_n = 0, m_op = 0, m_res = 0, exp_starts = 0;
    int res_dec = 0;

    operand_entry dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_num   (key_num),
        .key_tipo  (key_tipo),
        .alu_done  (alu_done),
        .res       (res),
        .reg1      (reg1),
        .reg2      (reg2),
        .op        (op),
        .OE        (OE),
        .alu_start (alu_start),
        .entry_full(entry_full)
    );

    always #5 clk = ~clk;

    // Count clock cycles in which alu_start is high
    always @(posedge clk) begin
        if (alu_start === 1'b1) starts <= starts + 1;
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_oe();
        case (m_ph)
            1: return 1;
            2, 3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reg1"}, 32'(reg1), 32'(to_bcd(m_a)));
        chk({tag, ".reg2"}, 32'(reg2), 32'(to_bcd(m_b)));
        chk({tag, ".op"}, 32'(op), 32'(m_op));
        chk({tag, ".OE"}, 32'(OE), 32'(exp_oe()));
        chk({tag, ".full"}, 32'(entry_full), 32'((m_ph == 1 || m_ph == 2) && m_n == 4));
        chk({tag, ".starts"}, 32'(starts), 32'(exp_starts));
    endtask

    task automatic model_clear();
        m_ph = 0; m_a = 0; m_b = 0; m_n = 0; m_op = 0;
    endtask

    task automatic model_key(input bit t, input int k);
        bit dig, opr;
        dig = !t && k <= 9;
        opr = t && k <= 3;
        if (t && k == 15) begin
            model_clear();
        end else begin
            case (m_ph)
                0: if (dig) begin m_a = k; m_n = 1; m_ph = 1; end
                1: begin
                    if (dig && m_n < 4) begin m_a = m_a * 10 + k; m_n++; end
                    else if (opr) begin m_op = k; m_b = 0; m_n = 0; m_ph = 2; end
                end
                2: begin
                    if (dig && m_n < 4) begin m_b = m_b * 10 + k; m_n++; end
                    else if (opr && m_n == 0) m_op = k;
                    else if (t && k == 14 && m_n >= 1) begin exp_starts++; m_ph = 3; end
                end
                4: begin
                    if (dig) begin m_a = k; m_b = 0; m_n = 1; m_ph = 1; end
                    else if (opr) begin m_a = m_res; m_b = 0; m_op = k; m_n = 0; m_ph = 2; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic press(input bit t, input int k, input int hold);
        @(negedge clk);
        key_valid = 1'b1;
        key_tipo  = t;
        key_num   = 4'(k);
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        key_num   = 4'($urandom);
        key_tipo  = 1'($urandom);
        @(negedge clk);
        model_key(t, k);
    endtask

    task automatic pulse_done(input int r);
        @(negedge clk);
        res_dec  = r;
        res      = to_bcd(r);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        if (m_ph == 3) begin m_ph = 4; m_res = r; end
    endtask

    initial begin
        int sel, k;
        // Power-on reset
        #3 reset = 1'b0;
        #1 check_all("por");
        @(negedge clk) reset = 1'b1;

        // T1: asynchronous reset in the middle of entry
        press(0, 1, 2);
        press(0, 2, 2);
        check_all("t1_pre");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all("t1_async");
        @(negedge clk) reset = 1'b1;

        // T2: five digits, the fifth is dropped
        for (int i = 1; i <= 5; i++) press(0, i, 2);
        check_all("t2");
        chk("t2.reg1_const", 32'(reg1), 32'h1234);

        // T3: operator B, second operand, equals, result
        press(1, int'(OP_B), 2);
        press(0, 5, 2);
        press(0, 6, 3);
        check_all("t3_b");
        chk("t3.reg2_const", 32'(reg2), 32'h0056);
        press(1, 14, 2);
        check_all("t3_eq");
        pulse_done(1290);
        check_all("t3_res");
        chk("t3.OE_const", 32'(OE), 32'(OE_RES));

        // T5: chaining from a shown result of 0099
        press(0, 3, 2);
        press(1, int'(OP_C), 2);
        press(0, 2, 2);
        press(1, 14, 2);
        pulse_done(99);
        press(1, int'(OP_A), 2);
        check_all("t5");
        chk("t5.reg1_const", 32'(reg1), 32'h0099);

        // '=' with an empty second operand is ignored; operator replaced
        press(1, 14, 2);
        press(1, int'(OP_D), 2);
        check_all("t5_empty_eq");

        // T6: clear and alu_done in the same cycle while waiting
        press(0, 4, 2);
        press(1, 14, 2);
        check_all("t6_wait");
        @(negedge clk);
        key_valid = 1'b1; key_tipo = 1'b1; key_num = 4'hF;
        @(negedge clk);
        alu_done = 1'b1; res = 16'h4321;
        @(negedge clk);
        alu_done = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        model_clear();
        check_all("t6_clr");
        press(1, 14, 2);
        check_all("t6_idle_eq");

        // T4: key held for ten cycles gives a single event
        press(0, 7, 10);
        check_all("t4");
        chk("t4.reg1_const", 32'(reg1), 32'h0007);

        // Reset while waiting on the ALU: no further start pulse
        press(1, int'(OP_A), 2);
        press(0, 8, 2);
        press(1, 14, 2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all("rst_wait");
        @(negedge clk) reset = 1'b1;
        repeat (5) @(negedge clk);
        check_all("rst_wait_after");

        // Randomized key and ALU activity
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45) begin
                press(0, $urandom_range(0, 11), $urandom_range(2, 5));
            end else if (sel < 85) begin
                k = $urandom_range(0, 19);
                if (k < 10) k = k % 4;
                else if (k < 15) k = 14;
                else if (k < 18) k = $urandom_range(4, 13);
                else k = 15;
                press(1, k, $urandom_range(2, 5));
            end else begin
                pulse_done(m_ph == 3 ? int'($urandom_range(0, 9999)) : res_dec);
            end
            check_all($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
